// File: rtl/uart_line_pkg.sv
// Shared character codes and state encodings for the uart line editor.
package uart_line_pkg;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BEL = 8'h07;
  localparam logic [7:0] CH_SP  = 8'h20;

  typedef enum logic {S_EDIT, S_HELD} ed_state_t;
  typedef enum logic {T_IDLE, T_WAIT} tx_state_t;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Three-byte echo queue drained through the uart tx_en/tx_rdy handshake.
module uart_tx_seq
  import uart_line_pkg::*;
(
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] cnt,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       empty
);

  logic [2:0][7:0] q;
  logic [1:0]      q_cnt;
  tx_state_t       st, st_n;
  logic            tx_en_n;
  logic [7:0]      tx_data_n;
  logic            pop;

  assign empty = (q_cnt == 2'd0);

  always_comb begin
    st_n      = st;
    tx_en_n   = tx_en;
    tx_data_n = tx_data;
    pop       = 1'b0;
    case (st)
      T_IDLE: if (!empty && tx_rdy) begin
        tx_en_n   = 1'b1;
        tx_data_n = q[0];
        st_n      = T_WAIT;
      end
      T_WAIT: if (!tx_rdy) begin
        // uart has taken the byte; the idle cycle guarantees a tx_en gap
        tx_en_n = 1'b0;
        pop     = 1'b1;
        st_n    = T_IDLE;
      end
      default: st_n = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      st      <= T_IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      q       <= '0;
      q_cnt   <= 2'd0;
    end else begin
      st      <= st_n;
      tx_en   <= tx_en_n;
      tx_data <= tx_data_n;
      if (load) begin
        q     <= {b2, b1, b0};
        q_cnt <= cnt;
      end else if (pop) begin
        q     <= {8'h00, q[2], q[1]};
        q_cnt <= q_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_line_editor.sv
// Line editor: buffers received bytes, echoes edits, hands completed lines to a consumer.
module uart_line_editor
  import uart_line_pkg::*;
#(
  parameter int LINE_LEN = 32,
  parameter int AW       = 5
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  input  logic          tx_rdy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  output logic          line_valid,
  output logic [AW:0]   line_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          line_ack,
  output logic          overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(LINE_LEN);

  logic [7:0]  mem [LINE_LEN];
  logic [AW:0] count, count_n;
  ed_state_t   state, state_n;
  logic        prev_rdy, ev;
  logic        pend_vld;
  logic [7:0]  pend;
  logic        q_empty;
  logic        proc, wr, ld, ovf_set;
  logic [1:0]  ld_cnt;
  logic [7:0]  e0, e1, e2;

  assign ev      = rx_rdy & ~prev_rdy;
  // every byte passes through the slot, which gives the one-cycle processing latency
  assign proc    = (state == S_EDIT) && pend_vld && q_empty;
  assign rd_data = mem[rd_addr];

  always_comb begin
    state_n = state;
    count_n = count;
    wr      = 1'b0;
    ld      = 1'b0;
    ld_cnt  = 2'd1;
    e0      = 8'h00;
    e1      = 8'h00;
    e2      = 8'h00;
    ovf_set = 1'b0;
    if (state == S_HELD) begin
      if (line_ack) begin
        state_n = S_EDIT;
        count_n = '0;
      end
    end else if (proc) begin
      if (is_print(pend)) begin
        ld = 1'b1;
        if (count < FULL) begin
          wr      = 1'b1;
          count_n = count + 1'b1;
          e0      = pend;
        end else begin
          ovf_set = 1'b1;
          e0      = CH_BEL;
        end
      end else if (pend == CH_BS || pend == CH_DEL) begin
        ld = 1'b1;
        if (count != '0) begin
          count_n = count - 1'b1;
          ld_cnt  = 2'd3;
          e0      = CH_BS;
          e1      = CH_SP;
          e2      = CH_BS;
        end else begin
          e0 = CH_BEL;
        end
      end else if (pend == CH_CR) begin
        ld      = 1'b1;
        ld_cnt  = 2'd2;
        e0      = CH_CR;
        e1      = CH_LF;
        state_n = S_HELD;
      end
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state      <= S_EDIT;
      count      <= '0;
      prev_rdy   <= 1'b0;
      pend_vld   <= 1'b0;
      pend       <= 8'h00;
      line_valid <= 1'b0;
      line_len   <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      prev_rdy <= rx_rdy;
      if (state == S_HELD) begin
        pend_vld <= 1'b0;
        if (line_ack) begin
          line_valid <= 1'b0;
          overflow   <= 1'b0;
        end
      end else begin
        if (proc) begin
          pend_vld <= ev;
          if (ev) pend <= rx_data;
        end else if (ev) begin
          if (!pend_vld) begin
            pend_vld <= 1'b1;
            pend     <= rx_data;
          end else begin
            overflow <= 1'b1;
          end
        end
        if (ovf_set) overflow <= 1'b1;
        if (state_n == S_HELD) begin
          line_valid <= 1'b1;
          line_len   <= count;
        end
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (wr) mem[count[AW-1:0]] <= pend;
  end

  uart_tx_seq u_tx_seq (
    .clk_50m (clk_50m),
    .rst     (rst),
    .load    (ld),
    .cnt     (ld_cnt),
    .b0      (e0),
    .b1      (e1),
    .b2      (e2),
    .tx_rdy  (tx_rdy),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_uart_line_editor.sv
// Directed bench for uart_line_editor with a simple uart transmitter model.
module tb_uart_line_editor;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_rdy = 1'b1;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       line_valid;
  logic [5:0] line_len;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       line_ack = 1'b0;
  logic       overflow;

  uart_line_editor #(.LINE_LEN(32), .AW(5)) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .tx_rdy     (tx_rdy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .line_valid (line_valid),
    .line_len   (line_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .line_ack   (line_ack),
    .overflow   (overflow)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int failures = 0;
  logic [7:0] log_q [$];
  logic stall = 1'b0;
  int ph = 0;
  int tc = 0;

  // uart model: logs each byte, drops tx_rdy two cycles later, idles three cycles
  initial begin
    forever begin
      @(negedge clk_50m);
      if (rst) begin
        ph = 0;
        tx_rdy = 1'b1;
      end else begin
        case (ph)
          0: if (tx_en) begin
            log_q.push_back(tx_data);
            ph = 1;
            tc = 0;
          end
          1: if (!stall) begin
            tc++;
            if (tc == 2) begin
              tx_rdy = 1'b0;
              ph = 2;
              tc = 0;
            end
          end
          default: begin
            tc++;
            if (tc == 3) begin
              tx_rdy = 1'b1;
              ph = 0;
            end
          end
        endcase
      end
    end
  end

  typedef struct {
    logic [7:0]      rx;
    int              n;
    logic [2:0][7:0] e;
  } vec_t;

  vec_t vt [12];

  function automatic vec_t mk(input logic [7:0] rx, input int n,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    vec_t v;
    v.rx = rx;
    v.n  = n;
    v.e  = {c, b, a};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_50m);
    rx_data = b;
    rx_rdy = 1'b1;
    repeat (2) @(negedge clk_50m);
    rx_rdy = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic ack();
    @(negedge clk_50m);
    line_ack = 1'b1;
    @(negedge clk_50m);
    line_ack = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(nm, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int base;
      base = log_q.size();
      send(vt[i].rx);
      repeat (40) @(negedge clk_50m);
      chk($sformatf("echo_count[%0d]", i), log_q.size(), base + vt[i].n);
      for (int j = 0; j < vt[i].n; j++)
        if (base + j < log_q.size())
          chk($sformatf("echo_byte[%0d.%0d]", i, j), {24'h0, log_q[base+j]}, {24'h0, vt[i].e[j]});
    end
  endtask

  initial begin
    int base;
    int bad;
    vt[0]  = mk(8'h61, 1, 8'h61, 8'h00, 8'h00);
    vt[1]  = mk(8'h62, 1, 8'h62, 8'h00, 8'h00);
    vt[2]  = mk(8'h0D, 2, 8'h0D, 8'h0A, 8'h00);
    vt[3]  = mk(8'h61, 1, 8'h61, 8'h00, 8'h00);
    vt[4]  = mk(8'h62, 1, 8'h62, 8'h00, 8'h00);
    vt[5]  = mk(8'h63, 1, 8'h63, 8'h00, 8'h00);
    vt[6]  = mk(8'h08, 3, 8'h08, 8'h20, 8'h08);
    vt[7]  = mk(8'h64, 1, 8'h64, 8'h00, 8'h00);
    vt[8]  = mk(8'h0D, 2, 8'h0D, 8'h0A, 8'h00);
    vt[9]  = mk(8'h0A, 0, 8'h00, 8'h00, 8'h00);
    vt[10] = mk(8'h7F, 1, 8'h07, 8'h00, 8'h00);
    vt[11] = mk(8'h0D, 2, 8'h0D, 8'h0A, 8'h00);

    repeat (3) @(negedge clk_50m);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // "ab" CR
    run_vecs(0, 2);
    chk("ab_valid", line_valid, 1);
    chk("ab_len", line_len, 2);
    rd_chk("ab_rd0", 5'd0, 8'h61);
    rd_chk("ab_rd1", 5'd1, 8'h62);
    ack();
    chk("ab_ack_valid", line_valid, 0);

    // "abc" BS "d" CR
    run_vecs(3, 8);
    chk("bs_len", line_len, 3);
    rd_chk("bs_rd0", 5'd0, 8'h61);
    rd_chk("bs_rd1", 5'd1, 8'h62);
    rd_chk("bs_rd2", 5'd2, 8'h64);
    ack();

    // LF ignored, DEL on empty line rings bell, CR gives an empty line
    run_vecs(9, 11);
    chk("empty_len", line_len, 0);
    chk("empty_valid", line_valid, 1);
    chk("empty_ovf", overflow, 0);
    ack();

    // fill the line, then one more
    base = log_q.size();
    for (int i = 0; i < 32; i++) begin
      send(8'h41 + 8'(i % 26));
      repeat (15) @(negedge clk_50m);
    end
    chk("fill_count", log_q.size(), base + 32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (base + i < log_q.size() && log_q[base+i] !== 8'h41 + 8'(i % 26)) bad++;
    chk("fill_echo_bad", bad, 0);
    chk("fill_ovf", overflow, 0);
    base = log_q.size();
    send(8'h23);
    repeat (20) @(negedge clk_50m);
    chk("full_echo_count", log_q.size(), base + 1);
    if (log_q.size() > base) chk("full_echo_bel", {24'h0, log_q[base]}, 32'h07);
    chk("full_ovf", overflow, 1);
    send(8'h0D);
    repeat (30) @(negedge clk_50m);
    chk("full_len", line_len, 32);
    rd_chk("full_rd31", 5'd31, 8'h46);
    ack();
    chk("full_ack_ovf", overflow, 0);
    chk("full_ack_valid", line_valid, 0);

    // bytes received while held are dropped silently
    send(8'h71);
    send(8'h0D);
    repeat (40) @(negedge clk_50m);
    chk("held_valid", line_valid, 1);
    base = log_q.size();
    send(8'h7A);
    repeat (20) @(negedge clk_50m);
    chk("held_no_tx", log_q.size(), base);
    chk("held_len", line_len, 1);
    chk("held_ovf", overflow, 0);
    rd_chk("held_rd0", 5'd0, 8'h71);
    ack();
    send(8'h78);
    repeat (20) @(negedge clk_50m);
    chk("x_echo_count", log_q.size(), base + 1);
    if (log_q.size() > base) chk("x_echo", {24'h0, log_q[base]}, 32'h78);
    rd_chk("x_rd0", 5'd0, 8'h78);

    // backspace echo stalled: second byte pending, third dropped
    stall = 1'b1;
    base = log_q.size();
    send(8'h08);
    repeat (10) @(negedge clk_50m);
    chk("stall_first", log_q.size(), base + 1);
    chk("stall_tx_en", tx_en, 1);
    send(8'h6D);
    chk("pend_ovf", overflow, 0);
    send(8'h6E);
    chk("drop_ovf", overflow, 1);
    stall = 1'b0;
    repeat (40) @(negedge clk_50m);
    chk("drain_count", log_q.size(), base + 4);
    if (log_q.size() >= base + 4) begin
      chk("drain_b1", {24'h0, log_q[base+1]}, 32'h20);
      chk("drain_b2", {24'h0, log_q[base+2]}, 32'h08);
      chk("drain_b3", {24'h0, log_q[base+3]}, 32'h6D);
    end
    rd_chk("pend_rd0", 5'd0, 8'h6D);

    // reset while the CR echo is stuck in the handshake
    stall = 1'b1;
    send(8'h0D);
    repeat (8) @(negedge clk_50m);
    chk("pre_rst_tx_en", tx_en, 1);
    chk("pre_rst_valid", line_valid, 1);
    @(negedge clk_50m);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_valid", line_valid, 0);
    chk("mid_rst_len", line_len, 0);
    chk("mid_rst_ovf", overflow, 0);
    stall = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    base = log_q.size();
    send(8'h6B);
    repeat (20) @(negedge clk_50m);
    chk("post_rst_count", log_q.size(), base + 1);
    if (log_q.size() > base) chk("post_rst_echo", {24'h0, log_q[base]}, 32'h6B);
    rd_chk("post_rst_rd0", 5'd0, 8'h6B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
